// File: rtl/decode_fwd_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_fwd_stage_pkg
//  Description : Shared constants for the Y86 decode/forwarding stage:
//                datapath widths, instruction codes, register indices and
//                the values loaded into the E register on a bubble.
//  Revision    : 1.0  initial release
// ============================================================================
package decode_fwd_stage_pkg;

    localparam int DEF_DATA_WID = 64;
    localparam int DEF_ADDR_WID = 4;

    // Register indices with special meaning
    localparam logic [3:0] DEF_RNONE = 4'hF;
    localparam logic [3:0] DEF_RSP   = 4'h4;

    // Instruction codes
    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Contents of the E register after a bubble or reset
    localparam logic [3:0] BUBBLE_ICODE = ICODE_NOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

endpackage : decode_fwd_stage_pkg
`default_nettype wire

// File: rtl/decode_fwd_stage_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Combinational 5-way priority forwarding mux. The first
//                source whose destination matches srcIdx supplies the value;
//                otherwise the register file value passes through. A source
//                index of RNONE never matches anything.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_select #(
    parameter int                DATA_WID = 64,
    parameter int                ADDR_WID = 4,
    parameter logic [ADDR_WID-1:0] RNONE  = '1
) (
    input  logic [ADDR_WID-1:0] srcIdx,
    input  logic [DATA_WID-1:0] regVal,
    input  logic [ADDR_WID-1:0] dst0,
    input  logic [DATA_WID-1:0] val0,
    input  logic [ADDR_WID-1:0] dst1,
    input  logic [DATA_WID-1:0] val1,
    input  logic [ADDR_WID-1:0] dst2,
    input  logic [DATA_WID-1:0] val2,
    input  logic [ADDR_WID-1:0] dst3,
    input  logic [DATA_WID-1:0] val3,
    input  logic [ADDR_WID-1:0] dst4,
    input  logic [DATA_WID-1:0] val4,
    output logic [DATA_WID-1:0] selVal
);

    // Lowest-numbered matching source wins; RNONE suppresses forwarding
    always_comb begin
        selVal = regVal;
        if (srcIdx != RNONE) begin
            if (srcIdx == dst0) begin
                selVal = val0;
            end else if (srcIdx == dst1) begin
                selVal = val1;
            end else if (srcIdx == dst2) begin
                selVal = val2;
            end else if (srcIdx == dst3) begin
                selVal = val3;
            end else if (srcIdx == dst4) begin
                selVal = val4;
            end
        end
    end

endmodule : fwd_select
`default_nettype wire

// File: rtl/decode_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_fwd_stage
//  Description : Y86 decode stage. Derives register read/write indices from
//                the D-stage fields, merges register file read data with
//                forwarded E/M/W results and captures the outcome in the E
//                pipeline register under stall/bubble control.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_fwd_stage
    import decode_fwd_stage_pkg::*;
#(
    parameter int                  DATA_WID = DEF_DATA_WID,
    parameter int                  ADDR_WID = DEF_ADDR_WID,
    parameter logic [ADDR_WID-1:0] RNONE    = ADDR_WID'(DEF_RNONE),
    parameter logic [ADDR_WID-1:0] RSP      = ADDR_WID'(DEF_RSP)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [3:0]          D_icode,
    input  logic [3:0]          D_ifun,
    input  logic [ADDR_WID-1:0] D_rA,
    input  logic [ADDR_WID-1:0] D_rB,
    input  logic [DATA_WID-1:0] D_valC,
    input  logic [DATA_WID-1:0] D_valP,
    output logic [ADDR_WID-1:0] srcA,
    output logic [ADDR_WID-1:0] srcB,
    input  logic [DATA_WID-1:0] valA,
    input  logic [DATA_WID-1:0] valB,
    input  logic [ADDR_WID-1:0] e_dstE,
    input  logic [ADDR_WID-1:0] M_dstE,
    input  logic [ADDR_WID-1:0] M_dstM,
    input  logic [ADDR_WID-1:0] W_dstE,
    input  logic [ADDR_WID-1:0] W_dstM,
    input  logic [DATA_WID-1:0] e_valE,
    input  logic [DATA_WID-1:0] M_valE,
    input  logic [DATA_WID-1:0] m_valM,
    input  logic [DATA_WID-1:0] W_valE,
    input  logic [DATA_WID-1:0] W_valM,
    input  logic                E_stall,
    input  logic                E_bubble,
    output logic [3:0]          E_icode,
    output logic [3:0]          E_ifun,
    output logic [DATA_WID-1:0] E_valC,
    output logic [DATA_WID-1:0] E_valA,
    output logic [DATA_WID-1:0] E_valB,
    output logic [ADDR_WID-1:0] E_dstE,
    output logic [ADDR_WID-1:0] E_dstM,
    output logic [ADDR_WID-1:0] E_srcA,
    output logic [ADDR_WID-1:0] E_srcB
);

    logic [ADDR_WID-1:0] w_srcA;
    logic [ADDR_WID-1:0] w_srcB;
    logic [ADDR_WID-1:0] w_dstE;
    logic [ADDR_WID-1:0] w_dstM;
    logic [DATA_WID-1:0] w_fwdA;
    logic [DATA_WID-1:0] w_fwdB;
    logic [DATA_WID-1:0] w_valA;

    logic [3:0]          r_icode;
    logic [3:0]          r_ifun;
    logic [DATA_WID-1:0] r_valC;
    logic [DATA_WID-1:0] r_valA;
    logic [DATA_WID-1:0] r_valB;
    logic [ADDR_WID-1:0] r_dstE;
    logic [ADDR_WID-1:0] r_dstM;
    logic [ADDR_WID-1:0] r_srcA;
    logic [ADDR_WID-1:0] r_srcB;

    // Register indices read and written by the instruction in D
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (D_icode)
            ICODE_RRMOVQ: begin
                w_srcA = D_rA;
                w_dstE = D_rB;
            end
            ICODE_IRMOVQ: begin
                w_dstE = D_rB;
            end
            ICODE_RMMOVQ: begin
                w_srcA = D_rA;
                w_srcB = D_rB;
            end
            ICODE_MRMOVQ: begin
                w_srcB = D_rB;
                w_dstM = D_rA;
            end
            ICODE_OPQ: begin
                w_srcA = D_rA;
                w_srcB = D_rB;
                w_dstE = D_rB;
            end
            ICODE_CALL: begin
                w_srcB = RSP;
                w_dstE = RSP;
            end
            ICODE_RET: begin
                w_srcA = RSP;
                w_srcB = RSP;
                w_dstE = RSP;
            end
            ICODE_PUSHQ: begin
                w_srcA = D_rA;
                w_srcB = RSP;
                w_dstE = RSP;
            end
            ICODE_POPQ: begin
                w_srcA = RSP;
                w_srcB = RSP;
                w_dstE = RSP;
                w_dstM = D_rA;
            end
            default: begin
                w_srcA = RNONE;
            end
        endcase
    end

    assign srcA = w_srcA;
    assign srcB = w_srcB;

    fwd_select #(
        .DATA_WID (DATA_WID),
        .ADDR_WID (ADDR_WID),
        .RNONE    (RNONE)
    ) u_fwdA (
        .srcIdx (w_srcA),
        .regVal (valA),
        .dst0   (e_dstE),
        .val0   (e_valE),
        .dst1   (M_dstM),
        .val1   (m_valM),
        .dst2   (M_dstE),
        .val2   (M_valE),
        .dst3   (W_dstM),
        .val3   (W_valM),
        .dst4   (W_dstE),
        .val4   (W_valE),
        .selVal (w_fwdA)
    );

    fwd_select #(
        .DATA_WID (DATA_WID),
        .ADDR_WID (ADDR_WID),
        .RNONE    (RNONE)
    ) u_fwdB (
        .srcIdx (w_srcB),
        .regVal (valB),
        .dst0   (e_dstE),
        .val0   (e_valE),
        .dst1   (M_dstM),
        .val1   (m_valM),
        .dst2   (M_dstE),
        .val2   (M_valE),
        .dst3   (W_dstM),
        .val3   (W_valM),
        .dst4   (W_dstE),
        .val4   (W_valE),
        .selVal (w_fwdB)
    );

    // Jumps and calls carry the fall-through PC down the valA lane
    always_comb begin
        w_valA = w_fwdA;
        if (D_icode == ICODE_JXX || D_icode == ICODE_CALL) begin
            w_valA = D_valP;
        end
    end

    // E pipeline register: bubble beats stall; reset loads the bubble
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_icode <= BUBBLE_ICODE;
            r_ifun  <= BUBBLE_IFUN;
            r_valC  <= '0;
            r_valA  <= '0;
            r_valB  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_srcA  <= RNONE;
            r_srcB  <= RNONE;
        end else if (E_bubble) begin
            r_icode <= BUBBLE_ICODE;
            r_ifun  <= BUBBLE_IFUN;
            r_valC  <= '0;
            r_valA  <= '0;
            r_valB  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_srcA  <= RNONE;
            r_srcB  <= RNONE;
        end else if (!E_stall) begin
            r_icode <= D_icode;
            r_ifun  <= D_ifun;
            r_valC  <= D_valC;
            r_valA  <= w_valA;
            r_valB  <= w_fwdB;
            r_dstE  <= w_dstE;
            r_dstM  <= w_dstM;
            r_srcA  <= w_srcA;
            r_srcB  <= w_srcB;
        end
    end

    assign E_icode = r_icode;
    assign E_ifun  = r_ifun;
    assign E_valC  = r_valC;
    assign E_valA  = r_valA;
    assign E_valB  = r_valB;
    assign E_dstE  = r_dstE;
    assign E_dstM  = r_dstM;
    assign E_srcA  = r_srcA;
    assign E_srcB  = r_srcB;

endmodule : decode_fwd_stage
`default_nettype wire

// File: tb/tb_decode_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_fwd_stage
//  Description : Self-checking bench for decode_fwd_stage. Directed cases
//                followed by randomized traffic compared against a
//                behavioural model of decode, forwarding and the E register.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_fwd_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA, valB;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        E_stall, E_bubble;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    decode_fwd_stage dut (
        .CLK(CLK), .RST_N(RST_N),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM),
        .W_valE(W_valE), .W_valM(W_valM),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    always #5 CLK = ~CLK;

    // Register file contents seen on the read ports
    logic [63:0] rf [16];

    // Expected E register contents
    logic [3:0]  xIcode, xIfun, xDstE, xDstM, xSrcA, xSrcB;
    logic [63:0] xValC, xValA, xValB;

    int nTotal = 0;
    int nBad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic setNop();
        xIcode = 4'h1; xIfun = 4'h0; xValC = '0; xValA = '0; xValB = '0;
        xDstE = 4'hF; xDstM = 4'hF; xSrcA = 4'hF; xSrcB = 4'hF;
    endtask

    task automatic checkE();
        chk("E_icode", E_icode, xIcode);
        chk("E_ifun",  E_ifun,  xIfun);
        chk("E_valC",  E_valC,  xValC);
        chk("E_valA",  E_valA,  xValA);
        chk("E_valB",  E_valB,  xValB);
        chk("E_dstE",  E_dstE,  xDstE);
        chk("E_dstM",  E_dstM,  xDstM);
        chk("E_srcA",  E_srcA,  xSrcA);
        chk("E_srcB",  E_srcB,  xSrcB);
    endtask

    // First in-flight result (youngest first) naming this register wins
    function automatic logic [63:0] fwdPick(input logic [3:0] src, input logic [63:0] rfv);
        logic [3:0]  d [5];
        logic [63:0] v [5];
        d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == 4'hF) return rfv;
        for (int i = 0; i < 5; i++) begin
            if (d[i] == src) return v[i];
        end
        return rfv;
    endfunction

    // One cycle: check decode indices, predict E, clock, check E
    task automatic step();
        logic [3:0]  ic, sA, sB, dE, dM;
        logic [63:0] vA, vB;
        ic = D_icode;
        sA = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? D_rA :
             (ic inside {4'h9, 4'hB})             ? 4'h4 : 4'hF;
        sB = (ic inside {4'h4, 4'h5, 4'h6})       ? D_rB :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        dE = (ic inside {4'h2, 4'h3, 4'h6})       ? D_rB :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        dM = (ic inside {4'h5, 4'hB}) ? D_rA : 4'hF;
        valA = rf[sA];
        valB = rf[sB];
        #1;
        chk("srcA", srcA, sA);
        chk("srcB", srcB, sB);
        vA = (ic inside {4'h7, 4'h8}) ? D_valP : fwdPick(sA, valA);
        vB = fwdPick(sB, valB);
        if (E_bubble) begin
            setNop();
        end else if (!E_stall) begin
            xIcode = ic; xIfun = D_ifun; xValC = D_valC; xValA = vA; xValB = vB;
            xDstE = dE; xDstM = dM; xSrcA = sA; xSrcB = sB;
        end
        @(posedge CLK);
        #1;
        checkE();
    endtask

    task automatic clearFwd();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        E_stall = 1'b0; E_bubble = 1'b0;
    endtask

    function automatic logic [3:0] rndReg();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    endfunction

    task automatic randomize_inputs();
        D_icode = 4'($urandom_range(0, 15));
        D_ifun  = 4'($urandom_range(0, 15));
        D_rA = rndReg(); D_rB = rndReg();
        D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
        e_dstE = rndReg(); M_dstE = rndReg(); M_dstM = rndReg();
        W_dstE = rndReg(); W_dstM = rndReg();
        e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
        m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
        W_valM = {$urandom, $urandom};
        E_stall  = ($urandom_range(0, 4) == 0);
        E_bubble = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = {$urandom, $urandom};
        D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = '0; D_valP = '0; valA = '0; valB = '0;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
        clearFwd();

        // Asynchronous reset takes effect before any clock edge
        #1 RST_N = 1'b0;
        #1;
        setNop();
        checkE();
        @(negedge CLK);
        RST_N = 1'b1;

        // OPQ without forwarding
        D_icode = 4'h6; D_ifun = 4'h0; D_rA = 4'h2; D_rB = 4'h3;
        D_valC = 64'h5; rf[2] = 64'h11; rf[3] = 64'h22;
        step();
        chk("opq_valA", E_valA, 64'h11);
        chk("opq_valB", E_valB, 64'h22);
        chk("opq_dstE", E_dstE, 64'h3);

        // Forwarding priority: e beats W, then m_valM beats lower stages
        e_dstE = 4'h2; e_valE = 64'hAA; W_dstE = 4'h2; W_valE = 64'hBB;
        step();
        chk("prio_e", E_valA, 64'hAA);
        e_dstE = 4'hF; M_dstM = 4'h2; m_valM = 64'hCC;
        step();
        chk("prio_m", E_valA, 64'hCC);

        // CALL: valP overrides valA, stack pointer forwarded from M
        clearFwd();
        D_icode = 4'h8; D_valP = 64'h100; M_dstE = 4'h4; M_valE = 64'h55;
        step();
        chk("call_valA", E_valA, 64'h100);
        chk("call_valB", E_valB, 64'h55);

        // POPQ index selection
        clearFwd();
        D_icode = 4'hB; D_rA = 4'h5; D_rB = 4'hF;
        step();
        chk("pop_dstE", E_dstE, 64'h4);
        chk("pop_dstM", E_dstM, 64'h5);

        // IRMOVQ: srcA is RNONE, so a RNONE destination must not forward
        D_icode = 4'h3; D_rA = 4'hF; D_rB = 4'h1;
        e_dstE = 4'hF; W_dstE = 4'hF; W_valE = 64'hDEAD; e_valE = 64'hBEEF;
        rf[15] = 64'h77;
        step();
        chk("irmov_valA", E_valA, 64'h77);

        // Stall holds E for two cycles while D changes
        clearFwd();
        D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
        step();
        E_stall = 1'b1;
        D_icode = 4'h2; D_rA = 4'h3;
        step();
        chk("stall1_icode", E_icode, 64'h6);
        D_icode = 4'h5; D_rB = 4'h0;
        step();
        chk("stall2_icode", E_icode, 64'h6);
        E_bubble = 1'b1;
        step();
        chk("bub_icode", E_icode, 64'h1);
        chk("bub_dstE", E_dstE, 64'hF);

        // Randomized traffic, with one reset in the middle of a cycle
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            if ($urandom_range(0, 9) == 0) rf[$urandom_range(0, 15)] = {$urandom, $urandom};
            step();
            if (n == 200) begin
                #3 RST_N = 1'b0;
                #1;
                setNop();
                checkE();
                #2 RST_N = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule : tb_decode_fwd_stage
`default_nettype wire
